// File: rtl/add_seq_ctrl.sv
// Multi-cycle wide adder: reuses one N-bit ripple adder over K cycles, LS word first.
// Optional subtract mode is enabled by defining ADD_SEQ_SUB_EN (adds the sub port).

module add #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[N];
   end

endmodule

// state  | meaning
// S_IDLE | waiting for start, result held
// S_RUN  | summing word idx, carry chained through carry register
// S_DONE | done pulse, result valid; start here launches back-to-back
module add_seq_ctrl #(
   parameter int N = 16,
   parameter int K = 4,
   localparam int W = N * K
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] rs1_reg,
   input  logic [W-1:0] rs2_reg,
   input  logic         cin,
`ifdef ADD_SEQ_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] add_rd,
   output logic         cout
);

   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           capture;
   logic           step;
   logic           last;

   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [W-1:0]   acc;
   logic [W-1:0]   acc_nxt;
   logic [IW-1:0]  idx;
   logic           carry;
   logic           sub_in;
   logic           sub_q;

   logic [N-1:0]   word_a;
   logic [N-1:0]   word_b;
   logic [N-1:0]   add_rd1;
   logic           word_cout;

`ifdef ADD_SEQ_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      step      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               capture   = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               capture   = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);
   assign last = (idx == IDX_LAST);

   // Subtract is A + ~B + ~cin, so the B inversion is applied per word here.
   assign word_a = op_a[idx * N +: N];
   assign word_b = op_b[idx * N +: N] ^ {N{sub_q}};

   add #(.N(N)) u_add (
      .a    (word_a),
      .b    (word_b),
      .cin  (carry),
      .sum  (add_rd1),
      .cout (word_cout)
   );

   always_comb begin
      acc_nxt                = acc;
      acc_nxt[idx * N +: N]  = add_rd1;
   end

   // Partial words collect in acc; add_rd only changes on the RUN->DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         acc    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         sub_q  <= 1'b0;
         add_rd <= '0;
         cout   <= 1'b0;
      end else if (capture) begin
         op_a  <= rs1_reg;
         op_b  <= rs2_reg;
         sub_q <= sub_in;
         carry <= cin ^ sub_in;
         idx   <= '0;
      end else if (step) begin
         acc   <= acc_nxt;
         carry <= word_cout;
         idx   <= idx + 1'b1;
         if (last) begin
            add_rd <= acc_nxt;
            cout   <= word_cout;
         end
      end
   end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl (N=16, K=4); define ADD_SEQ_SUB_EN to cover subtract.

module tb_add_seq_ctrl;

   localparam int N = 16;
   localparam int K = 4;
   localparam int W = N * K;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] rs1_reg;
   logic [W-1:0] rs2_reg;
   logic         cin;
`ifdef ADD_SEQ_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] add_rd;
   logic         cout;

   typedef struct packed {
      logic [W-1:0] rd;
      logic         co;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           vectors = 0;
   int           miscompares = 0;
   logic [W-1:0] held_rd;
   logic         held_co;

   always #5 clk = ~clk;

   add_seq_ctrl #(.N(N), .K(K)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rs1_reg (rs1_reg),
      .rs2_reg (rs2_reg),
      .cin     (cin),
`ifdef ADD_SEQ_SUB_EN
      .sub     (sub),
`endif
      .busy    (busy),
      .done    (done),
      .add_rd  (add_rd),
      .cout    (cout)
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic s);
      logic [W:0]   t;
      logic [W-1:0] bb;
      exp_t         r;
      bb   = s ? ~b : b;
      t    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci ^ s};
      r.rd = t[W-1:0];
      r.co = t[W];
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic s, input bit expect_it);
      rs1_reg = a;
      rs2_reg = b;
      cin     = ci;
`ifdef ADD_SEQ_SUB_EN
      sub     = s;
`endif
      start   = 1'b1;
      if (expect_it) sb.push_back(model(a, b, ci, s));
   endtask

   task automatic pop_exp(output exp_t x);
      if (sb.size() == 0) begin
         x = '0;
         miscompares++;
         $display("FAIL scoreboard_empty: got empty queue want one entry");
      end else begin
         x = sb.pop_front();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; rs1_reg = '1; rs2_reg = '1; cin = 1'b1;
`ifdef ADD_SEQ_SUB_EN
      sub = 1'b0;
`endif
      tick; tick;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (add_rd !== '0) begin miscompares++; $display("FAIL reset_add_rd: got %h want 0", add_rd); end
      vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", cout); end
      rst = 1'b0;
      tick;
      vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", busy, done);
      end
      held_rd = '0; held_co = 1'b0;
   endtask

   task automatic test_basic_add;
      logic [W-1:0] ta[8];
      logic [W-1:0] tb_[8];
      logic         tc[8];
      ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[0] = 64'h1; tc[0] = 1'b0;
      ta[1] = 64'h0000_0000_0000_FFFF; tb_[1] = 64'h1; tc[1] = 1'b0;
      ta[2] = 64'h0;                   tb_[2] = 64'h0; tc[2] = 1'b1;
      ta[3] = 64'h0000_FFFF_0000_FFFF; tb_[3] = 64'h0000_0000_FFFF_0001; tc[3] = 1'b1;
      for (int v = 4; v < 8; v++) begin
         ta[v]  = {$urandom, $urandom};
         tb_[v] = {$urandom, $urandom};
         tc[v]  = 1'($urandom_range(0, 1));
      end
      for (int v = 0; v < 8; v++) begin
         start_op(ta[v], tb_[v], tc[v], 1'b0, 1'b1);
         tick;
         start = 1'b0;
         rs1_reg = {$urandom, $urandom};
         rs2_reg = {$urandom, $urandom};
         cin = ~cin;
         for (int c = 1; c <= K; c++) begin
            vectors++; if (busy !== 1'b1 || done !== 1'b0) begin
               miscompares++; $display("FAIL add%0d_run_cyc%0d: got busy=%b done=%b want 1/0", v, c, busy, done);
            end
            vectors++; if (add_rd !== held_rd || cout !== held_co) begin
               miscompares++; $display("FAIL add%0d_hold_cyc%0d: got %h/%b want %h/%b", v, c, add_rd, cout, held_rd, held_co);
            end
            tick;
         end
         vectors++; if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL add%0d_done: got done=%b busy=%b want 1/0", v, done, busy);
         end
         pop_exp(e);
         vectors++; if (add_rd !== e.rd || cout !== e.co) begin
            miscompares++; $display("FAIL add%0d_result: got %h/%b want %h/%b", v, add_rd, cout, e.rd, e.co);
         end
         held_rd = e.rd; held_co = e.co;
         tick;
         vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL add%0d_idle: got done=%b busy=%b want 0/0", v, done, busy);
         end
      end
   endtask

   task automatic test_start_ignored;
      int dones;
      start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b1);
      tick;
      start = 1'b0;
      rs1_reg = ~rs1_reg;
      tick;
      start_op(64'hDEAD_BEEF_0000_0001, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0, 1'b0);
      tick;
      start = 1'b0;
      dones = 0;
      for (int cyc = 3; cyc <= 9; cyc++) begin
         if (done === 1'b1) dones++;
         if (cyc == 5) begin
            pop_exp(e);
            vectors++; if (done !== 1'b1 || add_rd !== e.rd || cout !== e.co) begin
               miscompares++; $display("FAIL ignore_result: got done=%b %h/%b want 1 %h/%b", done, add_rd, cout, e.rd, e.co);
            end
            held_rd = e.rd; held_co = e.co;
         end
         tick;
      end
      vectors++; if (dones != 1) begin
         miscompares++; $display("FAIL ignore_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_rst_abort;
      start_op(64'hAAAA_BBBB_CCCC_DDDD, 64'h1, 1'b0, 1'b0, 1'b0);
      tick;
      start = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      vectors++; if (busy !== 1'b0 || done !== 1'b0 || add_rd !== '0 || cout !== 1'b0) begin
         miscompares++; $display("FAIL abort_outputs: got busy=%b done=%b %h/%b want 0 0 0/0", busy, done, add_rd, cout);
      end
      held_rd = '0; held_co = 1'b0;
      tick;
      start_op(64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
      tick;
      start = 1'b0;
      for (int cyc = 5; cyc <= 8; cyc++) begin
         vectors++; if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL abort_restart_cyc%0d: got done=%b busy=%b want 0/1", cyc, done, busy);
         end
         tick;
      end
      pop_exp(e);
      vectors++; if (done !== 1'b1 || add_rd !== e.rd || cout !== e.co) begin
         miscompares++; $display("FAIL abort_restart_result: got done=%b %h/%b want 1 %h/%b", done, add_rd, cout, e.rd, e.co);
      end
      tick;
      rst = 1'b1;
      start_op(64'h5, 64'h6, 1'b0, 1'b0, 1'b0);
      tick;
      rst = 1'b0;
      start = 1'b0;
      vectors++; if (busy !== 1'b0 || done !== 1'b0 || add_rd !== '0) begin
         miscompares++; $display("FAIL rst_wins: got busy=%b done=%b %h want 0 0 0", busy, done, add_rd);
      end
      tick;
      vectors++; if (busy !== 1'b0) begin
         miscompares++; $display("FAIL rst_start_dropped: got busy=%b want 0", busy);
      end
      held_rd = '0; held_co = 1'b0;
   endtask

   task automatic test_back_to_back;
      start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0007, 1'b0, 1'b0, 1'b1);
      tick;
      start = 1'b0;
      for (int c = 1; c <= K; c++) tick;
      pop_exp(e);
      vectors++; if (done !== 1'b1 || add_rd !== e.rd || cout !== e.co) begin
         miscompares++; $display("FAIL b2b_first: got done=%b %h/%b want 1 %h/%b", done, add_rd, cout, e.rd, e.co);
      end
      held_rd = e.rd; held_co = e.co;
      start_op(64'h2, 64'h3, 1'b0, 1'b0, 1'b1);
      tick;
      start = 1'b0;
      for (int cyc = 6; cyc <= 9; cyc++) begin
         vectors++; if (busy !== 1'b1 || done !== 1'b0 || add_rd !== held_rd || cout !== held_co) begin
            miscompares++; $display("FAIL b2b_cyc%0d: got busy=%b done=%b %h/%b want 1 0 %h/%b",
                                    cyc, busy, done, add_rd, cout, held_rd, held_co);
         end
         tick;
      end
      pop_exp(e);
      vectors++; if (done !== 1'b1 || add_rd !== e.rd || cout !== e.co) begin
         miscompares++; $display("FAIL b2b_second: got done=%b %h/%b want 1 %h/%b", done, add_rd, cout, e.rd, e.co);
      end
      held_rd = e.rd; held_co = e.co;
      tick;
   endtask

`ifdef ADD_SEQ_SUB_EN
   task automatic test_sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic         ci;
      for (int v = 0; v < 6; v++) begin
         case (v)
            0: begin a = 64'd5; b = 64'd7; s = 1'b1; ci = 1'b0; end
            1: begin a = 64'd7; b = 64'd5; s = 1'b1; ci = 1'b0; end
            2: begin a = 64'h0001_0000_0000_0000; b = 64'h1; s = 1'b1; ci = 1'b0; end
            default: begin
               a = {$urandom, $urandom}; b = {$urandom, $urandom};
               s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
            end
         endcase
         start_op(a, b, ci, s, 1'b1);
         tick;
         start = 1'b0;
         sub = ~sub;
         for (int c = 1; c <= K; c++) tick;
         pop_exp(e);
         vectors++; if (done !== 1'b1 || add_rd !== e.rd || cout !== e.co) begin
            miscompares++; $display("FAIL sub%0d_result: got done=%b %h/%b want 1 %h/%b", v, done, add_rd, cout, e.rd, e.co);
         end
         tick;
      end
   endtask
`endif

   initial begin
      test_reset;
      test_basic_add;
      test_start_ignored;
      test_rst_abort;
      test_back_to_back;
`ifdef ADD_SEQ_SUB_EN
      test_sub;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
